// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port BRAM between fetch, data and debug
// requesters. Grants are combinational and one-hot. Read results return
// RD_LAT cycles later, tagged with their owner. A starvation counter
// temporarily lifts the debug port to top priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam logic [1:0] OWN_IF  = 2'd0;
    localparam logic [1:0] OWN_MEM = 2'd1;
    localparam logic [1:0] OWN_DBG = 2'd2;

    logic [7:0]              starve_cnt;
    logic                    aging;
    logic                    push_vld;
    logic [1:0]              push_own;
    logic [RD_LAT:1]         vld_pipe;
    logic [RD_LAT:1][1:0]    own_pipe;
    logic [1:0]              req_sum;
    logic                    tail_vld;

    // Debug has waited long enough: it overrides everyone this cycle.
    assign aging = dbg_req && (starve_cnt >= 8'(STARVE_MAX));

    // One-hot grant: aging dbg, else mem > if > dbg; nothing while in reset.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (aging)        dbg_gnt = 1'b1;
            else if (mem_req) mem_gnt = 1'b1;
            else if (if_req)  if_gnt  = 1'b1;
            else if (dbg_req) dbg_gnt = 1'b1;
        end
    end

    // Steer the winner onto the BRAM port; bus is all-zero when idle.
    always_comb begin
        bram_en    = if_gnt | mem_gnt | dbg_gnt;
        bram_we    = mem_gnt & mem_we;
        bram_addr  = '0;
        bram_wdata = '0;
        if (mem_gnt) begin
            bram_addr  = mem_addr;
            bram_wdata = mem_wdata;
        end else if (if_gnt) begin
            bram_addr  = if_addr;
        end else if (dbg_gnt) begin
            bram_addr  = dbg_addr;
        end
    end

    // Every read grant enters the return pipe; writes never produce a return.
    assign push_vld = bram_en & ~bram_we;
    assign push_own = mem_gnt ? OWN_MEM : (dbg_gnt ? OWN_DBG : OWN_IF);

    // Return pipe: RD_LAT stages of {valid, owner}, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe[1] <= push_vld;
            own_pipe[1] <= push_own;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                own_pipe[k] <= own_pipe[k-1];
            end
        end
    end

    // Tail decode; gated by rst so outputs are quiet from the first reset cycle.
    assign tail_vld   = vld_pipe[RD_LAT] & ~rst;
    assign if_rvalid  = tail_vld && (own_pipe[RD_LAT] == OWN_IF);
    assign mem_rvalid = tail_vld && (own_pipe[RD_LAT] == OWN_MEM);
    assign dbg_rvalid = tail_vld && (own_pipe[RD_LAT] == OWN_DBG);
    assign rdata      = tail_vld ? bram_rdata : '0;

    // Starvation age: counts denied dbg cycles, saturating, cleared on grant/idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (dbg_req && !dbg_gnt) begin
            if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    assign req_sum = {1'b0, if_req} + {1'b0, mem_req} + {1'b0, dbg_req};

    // Contention statistic: cycles with two or more requesters, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (req_sum >= 2'd2 && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data BRAM between three requesters:
  - core instruction fetch (IF stage);
  - core data access (MEM stage);
  - the debug/inference read port used to inspect memory (`infer`/`infer_addr` path).
- Sits between the multicycle control unit/datapath and the BRAM.
- Grants at most one access per cycle and returns read data with a per-requester valid, RD_LAT cycles after grant.
- Bounds debug-port starvation with an aging counter.

Parameters:
- ADDR_W, 16, BRAM word-address width.
- DATA_W, 32, BRAM data width.
- RD_LAT, 1, BRAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 8, number of consecutive denied dbg cycles after which dbg takes top priority; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  rdata holds fetch result.
- mem_req  in  1  data request; held until mem_gnt.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_gnt  out  1  data access granted this cycle.
- mem_rvalid  out  1  rdata holds load result.
- dbg_req  in  1  debug read request; held until dbg_gnt.
- dbg_addr  in  ADDR_W  debug address.
- dbg_gnt  out  1  debug granted this cycle.
- dbg_rvalid  out  1  rdata holds debug result.
- rdata  out  DATA_W  shared read-return bus.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after bram_en.
- conflict_cnt  out  16  saturating count of cycles with two or more requests pending.

Behaviour:
- Handshake:
  - A requester raises req with its address (and data) stable and holds them until it samples gnt=1 at a rising edge.
  - It may deassert req the cycle after the grant.
  - req dropped before grant is permitted; it simply leaves arbitration.
- Grant is combinational from the current req values, the aging state, and rst. It is one-hot or zero.
- All gnt outputs are forced 0 while rst=1.
- Priority, in normal mode: mem > if > dbg.
- Aging mode:
  - starve_cnt (8-bit) increments each cycle dbg_req=1 and dbg_gnt=0.
  - It clears to 0 on dbg_gnt=1 or dbg_req=0.
  - When starve_cnt >= STARVE_MAX, priority becomes dbg > mem > if for that cycle.
  - The counter saturates at 255.
- BRAM drive (combinational in the grant cycle):
  - bram_en = any gnt.
  - bram_addr and bram_wdata come from the winner.
  - bram_we = mem_gnt & mem_we.
  - When idle: bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
- Return pipeline:
  - A RD_LAT-deep shift register carries {valid, owner[1:0]}.
  - An entry is pushed on every read grant; writes push valid=0.
  - At the pipeline tail, exactly one of if_rvalid, mem_rvalid, dbg_rvalid is asserted per owner.
  - rdata = bram_rdata passed through combinationally when a tail entry is valid, else 0.
- Throughput: back-to-back grants on consecutive cycles are allowed; one read result per cycle. No bubbles are inserted.
- Writes complete at grant and produce no rvalid.
- conflict_cnt:
  - Increments on each cycle where at least two of if_req, mem_req, dbg_req are 1.
  - Saturates at 16'hFFFF.
- Reset:
  - On a rising edge with rst=1, the following are cleared: return pipeline (in-flight reads are dropped and no rvalid emerges afterwards), starve_cnt, and conflict_cnt.
  - Reset values: all gnt 0, all rvalid 0, rdata 0, bram_en 0, bram_we 0, conflict_cnt 0.
- Simultaneous events:
  - A new grant and a tail return in the same cycle are independent.
  - The same requester may receive a gnt while its previous rvalid is still in flight.
  - The aging override wins over a simultaneous mem write.

Test Plan:
- Single fetch: rst then if_req=1, if_addr=16'h0010, bram returns 32'h8C220004 → if_gnt=1 at cycle 0, bram_en=1, bram_addr=16'h0010, if_rvalid=1 with rdata=32'h8C220004 at cycle RD_LAT(=1); other rvalids 0.
- Priority: if_req, mem_req (read, 16'h0200), and dbg_req (addr 16'd6301) all high from cycle 0; if holds req only until its grant → cycle 0 mem_gnt, cycle 1 if_gnt, cycle 2 dbg_gnt; rvalids in the same order at cycles 1, 2, 3; conflict_cnt=2.
- Starvation: mem_req held high continuously, dbg_req=1, STARVE_MAX=8 → dbg_gnt=1 on the 9th cycle, starve_cnt returns to 0, mem granted again the next cycle.
- Write: mem_req=1, mem_we=1, addr 16'h0040, wdata 32'hDEADBEEF → bram_we=1, bram_wdata=32'hDEADBEEF for one cycle; no mem_rvalid; a subsequent read of 16'h0040 returns 32'hDEADBEEF.
- Reset mid-flight: RD_LAT=3, dbg read granted, rst pulsed one cycle later → no dbg_rvalid ever appears; conflict_cnt=0; all gnt=0 during rst.
- Saturation: hold all three reqs (never granted to dbg beyond aging) for 70000 cycles → conflict_cnt=16'hFFFF and stays there.
